// File: rtl/spectrum_bar_vg_pkg.sv
// rtl/spectrum_bar_vg_pkg.sv - shared constants, FSM state type and clog2 helper
// Purpose: common definitions for the spectrum bar overlay generator.
// Ports: none (package).
package spectrum_vg_pkg;

  // 24-bit RGB primaries; each channel is either all-ones or zero
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] BLACK = 24'h000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DISPLAY
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spectrum_bar_vg_if.sv
// rtl/spectrum_bar_vg_if.sv - FFT result RAM read bus
// Purpose: groups the read strobe, address and returned magnitude.
// Ports (signals): data_req, RAM_address (master -> RAM), fft_data (RAM -> master, 1 cycle after data_req).
interface spectrum_bar_vg_if #(
  parameter int ADDR_W = 8,
  parameter int MAG_W  = 32
);
  logic              data_req;
  logic [ADDR_W-1:0] RAM_address;
  logic [MAG_W-1:0]  fft_data;

  modport master (output data_req, output RAM_address, input fft_data);
  modport slave  (input data_req, input RAM_address, output fft_data);
endinterface

// File: rtl/spectrum_bar_vg_bin_line_ram.sv
// rtl/spectrum_bar_vg_bin_line_ram.sv - simple dual-port per-bin value RAM
// Purpose: one write port, one registered read port (1-cycle read latency).
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out (valid the cycle after raddr).
module bin_line_ram
  import spectrum_vg_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 13,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/spectrum_bar_vg.sv
// rtl/spectrum_bar_vg.sv - FFT spectrum bar overlay with peak-hold markers
// Purpose: fetches FFT_POINT magnitudes each vertical blank, keeps bar heights and
//   decaying peaks, and draws bottom-anchored bars over active video.
// Ports: pix_clk, rst (sync, active high); act_x/act_y pixel position; vs_in/hs_in/de_in
//   timing in; scale_shift magnitude shift; peak_en marker enable; fft (FFT RAM read
//   bus, master); vs_out/hs_out/de_out timing delayed 2 cycles; r_out/g_out/b_out colour.
module spectrum_bar_vg
  import spectrum_vg_pkg::*;
#(
  parameter int COLOR_DEPTH = 8,
  parameter int X_BITS      = 13,
  parameter int Y_BITS      = 13,
  parameter int H_ACT       = 1280,
  parameter int V_ACT       = 720,
  parameter int FFT_POINT   = 256,
  parameter int BIN_W       = 4,
  parameter int MAG_W       = 32,
  parameter int PEAK_DECAY  = 2
) (
  input  logic                   pix_clk,
  input  logic                   rst,
  input  logic [X_BITS-1:0]      act_x,
  input  logic [Y_BITS-1:0]      act_y,
  input  logic                   vs_in,
  input  logic                   hs_in,
  input  logic                   de_in,
  input  logic [4:0]             scale_shift,
  input  logic                   peak_en,
  spectrum_bar_vg_if.master      fft,
  output logic                   vs_out,
  output logic                   hs_out,
  output logic                   de_out,
  output logic [COLOR_DEPTH-1:0] r_out,
  output logic [COLOR_DEPTH-1:0] g_out,
  output logic [COLOR_DEPTH-1:0] b_out
);

  localparam int ADDR_W  = clog2(FFT_POINT);
  localparam int BIN_SH  = clog2(BIN_W);
  // bars never extend past the active line
  localparam int BAR_END = (FFT_POINT * BIN_W < H_ACT) ? FFT_POINT * BIN_W : H_ACT;
  localparam logic [X_BITS:0]   X_LIMIT  = (X_BITS + 1)'(BAR_END);
  localparam logic [X_BITS-1:0] GAP_MASK = X_BITS'(BIN_W - 1);
  localparam logic [Y_BITS-1:0] V_MAX    = Y_BITS'(V_ACT);
  localparam logic [Y_BITS-1:0] Y_TOP    = Y_BITS'(V_ACT - 1);
  localparam logic [Y_BITS-1:0] DECAY    = Y_BITS'(PEAK_DECAY);

  state_t state, state_nx;

  logic              vs_d1, hs_d1, de_d1;
  logic              vs_rise;
  logic [ADDR_W:0]   cnt;          // MSB set = all requests issued (write tail)
  logic [4:0]        shift_q;
  logic              frame_valid, first_frame;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MAG_W-1:0]  mag_sh;
  logic [Y_BITS-1:0] h_new, p_dec, p_new;
  logic [Y_BITS-1:0] height_rd, peak_rd;
  logic [ADDR_W-1:0] pix_bin, peak_raddr;
  logic [Y_BITS-1:0] y_up_d1;
  logic              in_range_d1, gap_d1;
  logic [23:0]       colour;

  assign vs_rise = vs_in & ~vs_d1;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge pix_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (vs_rise) state_nx = ST_FETCH;
      ST_FETCH: begin
        if (vs_rise)          state_nx = ST_FETCH;   // abort and restart at bin 0
        else if (cnt[ADDR_W]) state_nx = ST_DISPLAY; // last write lands this cycle
      end
      ST_DISPLAY: if (vs_rise) state_nx = ST_FETCH;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // rst gates the strobe directly so a reset mid-fetch stops requests at once
  always_comb begin
    fft.data_req    = (state == ST_FETCH) && !cnt[ADDR_W] && !rst;
    fft.RAM_address = cnt[ADDR_W-1:0];
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      cnt         <= '0;
      shift_q     <= '0;
      frame_valid <= 1'b0;
      first_frame <= 1'b1;
    end else begin
      if (vs_rise) begin
        cnt     <= '0;
        shift_q <= scale_shift;
      end else if (state == ST_FETCH && !cnt[ADDR_W]) begin
        cnt <= cnt + 1'b1;
      end
      if (state == ST_FETCH && cnt[ADDR_W] && !vs_rise) begin
        frame_valid <= 1'b1;
        first_frame <= 1'b0;
      end
    end
  end

  // ---------------- capture pipe ----------------
  // fft_data and the old peak both arrive one cycle after the request
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en   <= fft.data_req;
      wr_addr <= fft.RAM_address;
    end
  end

  assign mag_sh = fft.fft_data >> shift_q;
  assign h_new  = (mag_sh > MAG_W'(V_ACT)) ? V_MAX : mag_sh[Y_BITS-1:0];
  assign p_dec  = (peak_rd > DECAY) ? (peak_rd - DECAY) : '0;
  assign p_new  = first_frame ? h_new : ((h_new > p_dec) ? h_new : p_dec);

  assign pix_bin    = ADDR_W'(act_x >> BIN_SH);
  // the peak RAM read port serves the read-modify-write during fetch, pixels otherwise
  assign peak_raddr = (state == ST_FETCH) ? fft.RAM_address : pix_bin;

  bin_line_ram #(.DEPTH(FFT_POINT), .WIDTH(Y_BITS), .AW(ADDR_W)) u_height_ram (
    .clk   (pix_clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (h_new),
    .raddr (pix_bin),
    .rdata (height_rd)
  );

  bin_line_ram #(.DEPTH(FFT_POINT), .WIDTH(Y_BITS), .AW(ADDR_W)) u_peak_ram (
    .clk   (pix_clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (p_new),
    .raddr (peak_raddr),
    .rdata (peak_rd)
  );

  // ---------------- pixel pipe stage 1 ----------------
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vs_d1       <= 1'b0;
      hs_d1       <= 1'b0;
      de_d1       <= 1'b0;
      y_up_d1     <= '0;
      in_range_d1 <= 1'b0;
      gap_d1      <= 1'b0;
    end else begin
      vs_d1       <= vs_in;
      hs_d1       <= hs_in;
      de_d1       <= de_in;
      y_up_d1     <= Y_TOP - act_y;
      in_range_d1 <= {1'b0, act_x} < X_LIMIT;
      gap_d1      <= (act_x & GAP_MASK) == GAP_MASK;
    end
  end

  // ---------------- pixel pipe stage 2 ----------------
  always_comb begin
    colour = BLUE;
    if (!de_d1)                             colour = BLACK;
    else if (!frame_valid || !in_range_d1)  colour = BLUE;
    else if (gap_d1)                        colour = BLACK;
    else if (peak_en && peak_rd != '0 && y_up_d1 == peak_rd - Y_BITS'(1))
                                            colour = GREEN;
    else if (y_up_d1 < height_rd)           colour = RED;
    else                                    colour = BLUE;
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vs_out <= 1'b0;
      hs_out <= 1'b0;
      de_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else begin
      vs_out <= vs_d1;
      hs_out <= hs_d1;
      de_out <= de_d1;
      r_out  <= {COLOR_DEPTH{|colour[23:16]}};
      g_out  <= {COLOR_DEPTH{|colour[15:8]}};
      b_out  <= {COLOR_DEPTH{|colour[7:0]}};
    end
  end

endmodule

// File: tb/tb_spectrum_bar_vg.sv
// tb/tb_spectrum_bar_vg.sv - self-checking bench for spectrum_bar_vg
module tb_spectrum_bar_vg;

  localparam logic [23:0] C_RED   = 24'hFF0000;
  localparam logic [23:0] C_GREEN = 24'h00FF00;
  localparam logic [23:0] C_BLUE  = 24'h0000FF;
  localparam logic [23:0] C_BLACK = 24'h000000;

  typedef struct {
    int          x;
    int          y;
    bit          de;
    bit          pe;
    logic [23:0] rgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] act_x, act_y;
  logic        vs_in, hs_in, de_in;
  logic [4:0]  scale_shift;
  logic        peak_en;
  logic        vs_out, hs_out, de_out;
  logic [7:0]  r_out, g_out, b_out;

  logic [31:0] mag [256];
  int          req_count = 0;
  int          req_log[$];
  int          n_checks = 0;
  int          n_fail = 0;

  spectrum_bar_vg_if #(.ADDR_W(8), .MAG_W(32)) bus ();

  spectrum_bar_vg dut (
    .pix_clk     (clk),
    .rst         (rst),
    .act_x       (act_x),
    .act_y       (act_y),
    .vs_in       (vs_in),
    .hs_in       (hs_in),
    .de_in       (de_in),
    .scale_shift (scale_shift),
    .peak_en     (peak_en),
    .fft         (bus),
    .vs_out      (vs_out),
    .hs_out      (hs_out),
    .de_out      (de_out),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out)
  );

  always #5 clk = ~clk;

  // FFT result RAM model: data one cycle after the request
  always @(posedge clk) begin
    bus.fft_data <= bus.data_req ? mag[bus.RAM_address] : 32'h0;
    if (bus.data_req) begin
      req_log.push_back(int'(bus.RAM_address));
      req_count++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pix(input string name, input int x, input int y, input bit de,
                     input bit pe, input logic [23:0] exp);
    act_x   = 13'(x);
    act_y   = 13'(y);
    de_in   = de;
    peak_en = pe;
    tick();
    tick();
    check(name, {39'h0, de_out, r_out, g_out, b_out}, {39'h0, de, exp});
  endtask

  task automatic run_frame(input string name);
    int c0;
    de_in = 1'b0;
    c0    = req_count;
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    repeat (270) tick();
    check({name, " reqs"}, 64'(req_count - c0), 64'd256);
    check({name, " req idle"}, {63'h0, bus.data_req}, 64'h0);
  endtask

  task automatic wait_addr(input string name, input int addr);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.data_req && bus.RAM_address == 8'(addr)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout waiting for address %0d", name, addr);
    end
  endtask

  vec_t        tab [12];
  logic [2:0]  tpat [10];

  initial begin
    int bad;

    for (int i = 0; i < 256; i++) mag[i] = 32'h0;
    rst = 1'b1; act_x = '0; act_y = '0; vs_in = 0; hs_in = 0; de_in = 1;
    scale_shift = '0; peak_en = 0;

    // 1. reset with de_in high: everything quiet
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset outputs", {53'h0, de_out, vs_out, hs_out, bus.data_req, r_out, g_out, b_out}, 64'h0);
    end
    rst = 1'b0;
    pix("pre-fetch blue", 30, 10, 1, 0, C_BLUE);
    pix("pre-fetch bar area blue", 20, 719, 1, 0, C_BLUE);

    // 2. single bar, bin 5, h = 0x1400 >> 5 = 160
    tab[0]  = '{20, 719, 1'b1, 1'b0, C_RED};    // y_up 0
    tab[1]  = '{20, 560, 1'b1, 1'b0, C_RED};    // y_up 159, top row
    tab[2]  = '{21, 559, 1'b1, 1'b0, C_BLUE};   // y_up 160
    tab[3]  = '{22, 600, 1'b1, 1'b0, C_RED};
    tab[4]  = '{23, 700, 1'b1, 1'b0, C_BLACK};  // gap column of bin 5
    tab[5]  = '{19, 700, 1'b1, 1'b0, C_BLACK};  // gap column of bin 4
    tab[6]  = '{16, 700, 1'b1, 1'b0, C_BLUE};   // bin 4 empty
    tab[7]  = '{1024, 700, 1'b1, 1'b0, C_BLUE}; // past last bar
    tab[8]  = '{1023, 700, 1'b1, 1'b0, C_BLACK};// last bin gap
    tab[9]  = '{20, 560, 1'b1, 1'b1, C_GREEN};  // peak 160 marker at y_up 159
    tab[10] = '{21, 561, 1'b1, 1'b1, C_RED};
    tab[11] = '{20, 700, 1'b0, 1'b0, C_BLACK};  // blanking: zero colour
    mag[5] = 32'h1400;
    scale_shift = 5'd5;
    run_frame("frame bin5");
    for (int i = 0; i < 12; i++)
      pix($sformatf("bar vec %0d", i), tab[i].x, tab[i].y, tab[i].de, tab[i].pe, tab[i].rgb);

    // 3. saturation to V_ACT and timing delay
    mag[7] = 32'hFFFF_FFFF;
    scale_shift = 5'd0;
    run_frame("frame sat");
    pix("sat top row", 28, 0, 1, 0, C_RED);
    pix("sat bottom row", 28, 719, 1, 0, C_RED);
    pix("sat peak marker", 28, 0, 1, 1, C_GREEN);

    tpat[0] = 3'b001; tpat[1] = 3'b011; tpat[2] = 3'b101; tpat[3] = 3'b111; tpat[4] = 3'b000;
    tpat[5] = 3'b110; tpat[6] = 3'b010; tpat[7] = 3'b100; tpat[8] = 3'b001; tpat[9] = 3'b000;
    act_x = 13'd2000;
    for (int i = 0; i < 10; i++) begin
      {vs_in, hs_in, de_in} = tpat[i];
      tick();
      if (i >= 1)
        check($sformatf("timing delay %0d", i), {61'h0, vs_out, hs_out, de_out}, {61'h0, tpat[i-1]});
    end
    {vs_in, hs_in, de_in} = 3'b000;
    repeat (300) tick();

    // 4. peak hold decay on bin 10
    for (int i = 0; i < 256; i++) mag[i] = 32'h0;
    mag[10] = 32'd3200;
    scale_shift = 5'd5;
    run_frame("peak frame 1");
    pix("peak f1 marker", 40, 620, 1, 1, C_GREEN);
    pix("peak f1 below", 40, 621, 1, 1, C_RED);
    pix("peak f1 above", 40, 619, 1, 1, C_BLUE);
    mag[10] = 32'h0;
    run_frame("peak frame 2");
    pix("peak f2 marker", 40, 622, 1, 1, C_GREEN);
    pix("peak f2 old row", 40, 620, 1, 1, C_BLUE);
    run_frame("peak frame 3");
    pix("peak f3 marker", 40, 624, 1, 1, C_GREEN);
    pix("peak f3 disabled", 40, 624, 1, 0, C_BLUE);

    // 5. vs re-pulse at address 100 restarts the fetch
    mag[10] = 32'd3200;
    de_in = 1'b0;
    req_log.delete();
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    wait_addr("abort wait", 100);
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    repeat (300) tick();
    check("abort req total", 64'(req_log.size()), 64'd357);
    bad = 0;
    for (int i = 0; i < 101 && i < req_log.size(); i++) if (req_log[i] != i) bad++;
    check("abort first pass order", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < 256 && 101 + i < req_log.size(); i++) if (req_log[101 + i] != i) bad++;
    check("abort restart order", 64'(bad), 64'd0);
    pix("after abort bar", 40, 621, 1, 0, C_RED);

    // 6. reset mid-fetch
    de_in = 1'b0;
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    wait_addr("reset wait", 50);
    rst = 1'b1;
    #1;
    check("reset drops req", {63'h0, bus.data_req}, 64'h0);
    tick();
    check("reset req next cycle", {63'h0, bus.data_req}, 64'h0);
    rst = 1'b0;
    tick();
    check("reset req stays low", {63'h0, bus.data_req}, 64'h0);
    pix("after reset blue", 40, 621, 1, 0, C_BLUE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
